// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: transfer-state encoding and SDA/ACK line constants.
package i2c_pkg;

  // Transmit-path transfer state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } tx_state_e;

  // Value seen on SDA during the ACK slot
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Open-drain released line level
  localparam logic SDA_RELEASE = 1'b1;

endpackage : i2c_pkg

// File: rtl/i2c_tx_serialiser.sv
// I2C slave read-path transmitter: serialises one byte MSB-first on SDA,
// one bit per shift_en strobe, then releases SDA and samples the master ACK.
//
// Ports:
//   clk_i, rst_n  clock, asynchronous active-low reset
//   data_i        byte to send, captured on an accepted load
//   load_i        load request, accepted when ready_o is high
//   ready_o       high in IDLE only
//   shift_en      SCL-low strobe advancing to the next bit
//   ack_en        SCL-high strobe in the ACK slot sampling sda_i
//   sda_i         synchronised SDA line
//   abort_i       STOP / repeated START / bus error
//   sda_o         current data bit, 1 when idle or released
//   sda_oe_o      open-drain pull-low enable
//   done_o        one-cycle pulse when the ACK slot has been sampled
//   nack_o        last ACK slot result, held until the next accepted load
module i2c_tx_serialiser
  import i2c_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  output logic             ready_o,
  input  logic             shift_en,
  input  logic             ack_en,
  input  logic             sda_i,
  input  logic             abort_i,
  output logic             sda_o,
  output logic             sda_oe_o,
  output logic             done_o,
  output logic             nack_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             sda_q, sda_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= CNT_TOP;
      ready_q <= 1'b1;
      sda_q   <= SDA_RELEASE;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  // Next-state and next-output logic; abort outranks strobes, strobes outrank load
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    sda_d   = sda_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    nack_d  = nack_q;
    shifted = shreg_q << 1;

    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_TOP;
      ready_d = 1'b1;
      sda_d   = SDA_RELEASE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_i && ready_q) begin
            state_d = ST_SHIFT;
            shreg_d = data_i;
            cnt_d   = CNT_TOP;
            nack_d  = 1'b0;
            ready_d = 1'b0;
            sda_d   = data_i[WIDTH-1];
            oe_d    = ~data_i[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (cnt_q != '0) begin
              shreg_d = shifted;
              cnt_d   = cnt_q - CNT_W'(1);
              sda_d   = shifted[WIDTH-1];
              oe_d    = ~shifted[WIDTH-1];
            end else begin
              // Last bit done: release the line for the master's ACK
              state_d = ST_ACK;
              sda_d   = SDA_RELEASE;
              oe_d    = 1'b0;
            end
          end
        end
        ST_ACK: begin
          if (ack_en) begin
            state_d = ST_IDLE;
            nack_d  = sda_i;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_TOP;
          ready_d = 1'b1;
          sda_d   = SDA_RELEASE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign sda_o    = sda_q;
  assign sda_oe_o = oe_q;
  assign done_o   = done_q;
  assign nack_o   = nack_q;

endmodule : i2c_tx_serialiser

// File: doc/i2c_tx_serialiser.md
Name: i2c_tx_serialiser

Overview:
- Parallel-to-serial transmitter for the I2C slave read path; the counterpart of the slave's receive deserialiser.
- Accepts one byte from the register/data layer and presents it MSB-first on SDA, one bit per shift strobe from the slave bit-timing logic.
- After the last data bit, releases SDA and samples the master's ACK/NACK.
- Reports completion and the ACK/NACK result to the slave control FSM.

Parameters:
- WIDTH, 8: bits per transfer.
- CNT_W, $clog2(WIDTH): bit-counter width (derived; not overridden).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_i  input  WIDTH  byte to transmit; sampled only on an accepted load.
- load_i  input  1  load request; accepted when load_i and ready_o are both high.
- ready_o  output  1  high in IDLE only.
- shift_en  input  1  one-cycle strobe from the SCL-low phase that advances to the next bit.
- ack_en  input  1  one-cycle strobe on SCL high during the ACK slot that samples sda_i.
- sda_i  input  1  synchronised SDA line value.
- abort_i  input  1  STOP / repeated START / bus error; cancels the transfer.
- sda_o  output  1  current data bit; 1 when idle or released.
- sda_oe_o  output  1  open-drain pull-low enable; high only while driving a 0 data bit.
- done_o  output  1  one-cycle pulse when the ACK slot has been sampled.
- nack_o  output  1  result of the last ACK slot: 1 = NACK; held until the next accepted load.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, shift register = 0, bit counter = WIDTH-1.
  - ready_o = 1, sda_o = 1, sda_oe_o = 0, done_o = 0, nack_o = 0.
- States: IDLE, SHIFT, ACK. All outputs are registered.
- IDLE:
  - On load_i & ready_o: capture data_i into the shift register, set counter = WIDTH-1, clear nack_o, go to SHIFT.
  - From the next cycle: sda_o = data_i[WIDTH-1], sda_oe_o = ~data_i[WIDTH-1], ready_o = 0. Load-to-first-bit latency is 1 cycle.
  - shift_en and ack_en are ignored.
- SHIFT:
  - sda_o is always the shift-register MSB; sda_oe_o is always its inverse.
  - On shift_en with counter != 0: shift left one place (LSB fill 0) and decrement the counter; the new bit is visible 1 cycle later.
  - On shift_en with counter == 0: go to ACK with sda_o = 1, sda_oe_o = 0 (SDA released).
  - The line is therefore released on exactly the WIDTH-th shift_en after the load.
  - load_i and ack_en are ignored.
- ACK:
  - SDA stays released.
  - On ack_en: nack_o <= sda_i (0 = ACK, 1 = NACK), done_o pulses high for 1 cycle, go to IDLE, ready_o = 1 in the same cycle as done_o.
  - shift_en and load_i are ignored.
- abort_i (any state): next cycle state = IDLE, ready_o = 1, sda_o = 1, sda_oe_o = 0, counter = WIDTH-1. No done_o pulse; nack_o is unchanged.
- Priority when events coincide: abort_i, then ack_en/shift_en (as valid for the current state), then load_i.
  - abort_i together with load_i in IDLE: the load is not accepted.
- The slave control FSM may issue load_i in the same cycle that done_o is high.
  - The load is accepted if ready_o is already high that cycle.
  - Otherwise it is accepted on the following cycle.
- WIDTH is generic; the counter wraps only via reload, never by underflow.

Decomposition:
- Shared package i2c_pkg holds:
  - the transfer-state encoding (IDLE/SHIFT/ACK) as a typedef;
  - constants I2C_ACK = 1'b0 and I2C_NACK = 1'b1;
  - SDA_RELEASE = 1'b1.
- The deserialiser uses the same ACK constants.
- Single module; a sub-module is not warranted. The shift register and counter stay inline.

Test Plan:
- Load 0xA5, apply 8 shift_en strobes spaced 4 cycles apart, then ack_en with sda_i=0 -> sda_o sequence 1,0,1,0,0,1,0,1; sda_oe_o is its inverse; release after the 8th strobe; done_o pulses once; nack_o=0; ready_o=1.
- Load 0xFF, full byte, ack_en with sda_i=1 -> sda_oe_o never asserts; nack_o=1 is held; next load of 0x00 clears nack_o and sda_oe_o stays high for all 8 bits.
- Load 0x3C, abort_i after 3 shift_en -> next cycle: IDLE, sda_oe_o=0, sda_o=1, no done_o; a fresh load of 0x81 transmits from bit 7.
- load_i held high with data 0x55 while in SHIFT, and ack_en strobes during SHIFT -> the byte in flight (0xC3) is unaffected; no early ACK sample.
- rst_n asserted mid-byte (after 5 shifts of 0x96) -> immediately: all outputs at reset values; state IDLE; the counter restarts at WIDTH-1 on the next load.
- Same-cycle abort_i and load_i in IDLE -> the load is rejected: ready_o stays 1 and sda_oe_o stays 0.
